// File: rtl/pwm_pkg.sv
// Shared PWM definitions: scancodes, nominal high times, decoder state and classifier.
package pwm_pkg;

   localparam logic [7:0] SC_F    = 8'h2B;
   localparam logic [7:0] SC_Q    = 8'h15;
   localparam logic [7:0] SC_H    = 8'h33;
   localparam logic [7:0] SC_X    = 8'h22;
   localparam logic [7:0] SC_NONE = 8'h00;

   // Nominal high times in ticks produced by the generator for each key
   localparam int NOM_F = 41;
   localparam int NOM_Q = 51;
   localparam int NOM_H = 61;
   localparam int NOM_X = 81;

   localparam int PWM_PERIOD = 801;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } dec_state_t;

   typedef struct packed {
      logic       match;
      logic [7:0] code;
   } decode_t;

   function automatic logic in_window(input int h, input int nom, input int tol);
      return (h >= nom - tol) && (h <= nom + tol);
   endfunction

   // Windows are disjoint while tol < 5, so the order of the tests does not matter
   function automatic decode_t classify(input int h, input int tol);
      decode_t d;
      d.match = 1'b1;
      if (in_window(h, NOM_F, tol))      d.code = SC_F;
      else if (in_window(h, NOM_Q, tol)) d.code = SC_Q;
      else if (in_window(h, NOM_H, tol)) d.code = SC_H;
      else if (in_window(h, NOM_X, tol)) d.code = SC_X;
      else begin
         d.code  = SC_NONE;
         d.match = 1'b0;
      end
      return d;
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Mod-TICK_DIV prescaler: one-clk tick when the count sits at TICK_DIV-1.
module pwm_tick_gen #(
   parameter int TICK_DIV = 100
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign o_tick = (r_cnt == LAST);

   // Free-running counter, wraps to 0 on the tick cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       r_cnt <= '0;
      else if (o_tick) r_cnt <= '0;
      else             r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/pwm_decode.sv
// PWM receiver: measures high time and period in ticks, decodes the scancode,
// and flags a lost/stuck input.
module pwm_decode
   import pwm_pkg::*;
#(
   parameter int TICK_DIV = 100,
   parameter int CNT_W    = 10,
   parameter int TOL      = 2,
   parameter int TIMEOUT  = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic [7:0]       scancode,
   output logic             match,
   output logic             valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

   logic             r_sync1, r_sync2, r_sync_d;
   logic             w_rise, w_fall, w_tick;
   dec_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_hcnt, r_lcnt, w_hcnt_nxt, w_lcnt_nxt;
   logic [CNT_W-1:0] w_h_tick, w_l_tick;
   logic [CNT_W:0]   w_period_sum;
   logic [CNT_W-1:0] w_period_sat;
   logic             w_latch, w_to_evt;
   decode_t          w_dec;

   logic [CNT_W-1:0] r_high_cnt, r_period_cnt;
   logic [7:0]       r_scancode;
   logic             r_match, r_valid, r_timeout;

   pwm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .i_clk  (clk),
      .i_rst  (reset),
      .o_tick (w_tick)
   );

   // Two-flop synchronizer plus one delay stage for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_sync_d <= 1'b0;
      end else begin
         r_sync1  <= pwm_in;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
      end
   end

   assign w_rise = r_sync2 & ~r_sync_d;
   assign w_fall = ~r_sync2 & r_sync_d;

   // A tick in the edge cycle belongs to the phase that is ending
   assign w_h_tick = (w_tick && r_hcnt != CNT_MAX) ? r_hcnt + 1'b1 : r_hcnt;
   assign w_l_tick = (w_tick && r_lcnt != CNT_MAX) ? r_lcnt + 1'b1 : r_lcnt;

   assign w_period_sum = {1'b0, r_hcnt} + {1'b0, w_l_tick};
   assign w_period_sat = w_period_sum[CNT_W] ? CNT_MAX : w_period_sum[CNT_W-1:0];

   assign w_dec = classify(int'(r_hcnt), TOL);

   // State and phase-counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_hcnt  <= '0;
         r_lcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_hcnt  <= w_hcnt_nxt;
         r_lcnt  <= w_lcnt_nxt;
      end
   end

   // Next state, counter updates, latch and timeout events
   always_comb begin
      w_state_nxt = r_state;
      w_hcnt_nxt  = r_hcnt;
      w_lcnt_nxt  = r_lcnt;
      w_latch     = 1'b0;
      w_to_evt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
               w_hcnt_nxt  = '0;
               w_lcnt_nxt  = '0;
            end
         end
         ST_HIGH: begin
            w_hcnt_nxt = w_h_tick;
            if (w_fall) begin
               w_state_nxt = ST_LOW;
               w_lcnt_nxt  = '0;
            end else if (w_h_tick >= TO_VAL) begin
               w_to_evt    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOW: begin
            if (w_rise) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_HIGH;
               w_hcnt_nxt  = '0;
               w_lcnt_nxt  = '0;
            end else begin
               w_lcnt_nxt = w_l_tick;
               if (w_l_tick >= TO_VAL) begin
                  w_to_evt    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output registers: update on a completed period, hold through a timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_high_cnt   <= '0;
         r_period_cnt <= '0;
         r_scancode   <= SC_NONE;
         r_match      <= 1'b0;
         r_valid      <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_valid <= w_latch;
         if (w_latch) begin
            r_high_cnt   <= r_hcnt;
            r_period_cnt <= w_period_sat;
            r_scancode   <= w_dec.code;
            r_match      <= w_dec.match;
            r_timeout    <= 1'b0;
         end else if (w_to_evt) begin
            r_timeout <= 1'b1;
            r_match   <= 1'b0;
         end
      end
   end

   assign high_cnt   = r_high_cnt;
   assign period_cnt = r_period_cnt;
   assign scancode   = r_scancode;
   assign match      = r_match;
   assign valid      = r_valid;
   assign timeout    = r_timeout;

endmodule

// File: tb/tb_pwm_decode.sv
// Bench for pwm_decode: PWM periods are driven from tasks, expected measurements
// are queued per period and compared whenever the DUT pulses valid.
module tb_pwm_decode;

   localparam int TD      = 4;
   localparam int CNT_W   = 10;
   localparam int TOL     = 2;
   localparam int TIMEOUT = 900;
   localparam int PER     = 801;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             pwm_in = 1'b0;
   logic [CNT_W-1:0] high_cnt, period_cnt;
   logic [7:0]       scancode;
   logic             match, valid, timeout;

   typedef struct {
      int         h;
      int         p;
      logic [7:0] sc;
      logic       m;
      bit         chk_p;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   exp_t last_e;
   int   n_checks = 0;
   int   n_err    = 0;
   int   n_valid  = 0;

   pwm_decode #(.TICK_DIV(TD), .CNT_W(CNT_W), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .pwm_in     (pwm_in),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .scancode   (scancode),
      .match      (match),
      .valid      (valid),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic exp_t model(input int h, input int p, input bit cp);
      exp_t e;
      e.h = h; e.p = p; e.chk_p = cp; e.sc = 8'h00; e.m = 1'b0;
      if (iabs(h - 41) <= TOL)      begin e.sc = 8'h2B; e.m = 1'b1; end
      else if (iabs(h - 51) <= TOL) begin e.sc = 8'h15; e.m = 1'b1; end
      else if (iabs(h - 61) <= TOL) begin e.sc = 8'h33; e.m = 1'b1; end
      else if (iabs(h - 81) <= TOL) begin e.sc = 8'h22; e.m = 1'b1; end
      return e;
   endfunction

   // Scoreboard: every valid pops one expectation
   always @(negedge clk) begin
      if (valid) begin
         n_valid++;
         if (q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_valid: got valid=1 high=%0d, required no valid", high_cnt);
         end else begin
            m_e = q.pop_front();
            last_e = m_e;
            n_checks++;
            if (high_cnt !== CNT_W'(m_e.h)) begin
               n_err++; $display("FAIL high_cnt: got %0d required %0d", high_cnt, m_e.h);
            end
            if (m_e.chk_p) begin
               n_checks++;
               if (period_cnt !== CNT_W'(m_e.p)) begin
                  n_err++; $display("FAIL period_cnt: got %0d required %0d", period_cnt, m_e.p);
               end
            end
            n_checks++;
            if (scancode !== m_e.sc) begin
               n_err++; $display("FAIL scancode: got %02h required %02h (h=%0d)", scancode, m_e.sc, m_e.h);
            end
            n_checks++;
            if (match !== m_e.m) begin
               n_err++; $display("FAIL match: got %0b required %0b (h=%0d)", match, m_e.m, m_e.h);
            end
            n_checks++;
            if (timeout !== 1'b0) begin
               n_err++; $display("FAIL timeout_at_valid: got %0b required 0", timeout);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_period(input int h, input int p, input int extra, input bit push, input bit cp);
      if (push) q.push_back(model(h, p, cp));
      pwm_in = 1'b1;
      wait_clks(h * TD);
      pwm_in = 1'b0;
      wait_clks((p - h) * TD + extra);
   endtask

   task automatic test_reset();
      wait_clks(3);
      n_checks++;
      if ({high_cnt, period_cnt, scancode, match, valid, timeout} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got h=%0d p=%0d sc=%02h m=%0b v=%0b to=%0b required all 0",
                  high_cnt, period_cnt, scancode, match, valid, timeout);
      end
      reset = 1'b0;
      wait_clks(5);
   endtask

   task automatic test_basic();
      for (int i = 0; i < 3; i++) drive_period(41, PER, 0, 1'b1, 1'b1);
   endtask

   task automatic test_codes();
      drive_period(51, PER, 0, 1'b1, 1'b1);
      drive_period(61, PER, 0, 1'b1, 1'b1);
      drive_period(81, PER, 0, 1'b1, 1'b1);
   endtask

   task automatic test_tolerance();
      drive_period(43, PER, 0, 1'b1, 1'b1);
      drive_period(44, PER, 0, 1'b1, 1'b1);
      drive_period(70, PER, 0, 1'b1, 1'b1);
      drive_period(39, PER, 0, 1'b1, 1'b1);
   endtask

   // Shift the edge phase against the tick so every alignment is exercised,
   // including a rise on a tick cycle
   task automatic test_tick_phase();
      for (int s = 1; s <= 3; s++) begin
         drive_period(41, PER, s, 1'b1, 1'b0);
         drive_period(41, PER, 0, 1'b1, 1'b1);
      end
   endtask

   task automatic check_timeout_hold(input string tag, input int v0);
      wait_clks(TIMEOUT * TD - 8);
      n_checks++;
      if (timeout !== 1'b0) begin
         n_err++; $display("FAIL %s_early: got timeout=%0b required 0", tag, timeout);
      end
      wait_clks(16);
      n_checks++;
      if (timeout !== 1'b1) begin
         n_err++; $display("FAIL %s_timeout: got timeout=%0b required 1", tag, timeout);
      end
      n_checks++;
      if (high_cnt !== CNT_W'(last_e.h) || period_cnt !== CNT_W'(last_e.p) || scancode !== last_e.sc) begin
         n_err++;
         $display("FAIL %s_held: got h=%0d p=%0d sc=%02h required h=%0d p=%0d sc=%02h",
                  tag, high_cnt, period_cnt, scancode, last_e.h, last_e.p, last_e.sc);
      end
      n_checks++;
      if (match !== 1'b0) begin
         n_err++; $display("FAIL %s_match: got %0b required 0", tag, match);
      end
      n_checks++;
      if (n_valid !== v0) begin
         n_err++; $display("FAIL %s_no_valid: got %0d valids required %0d", tag, n_valid, v0);
      end
   endtask

   task automatic test_hold_high();
      int v0;
      pwm_in = 1'b1;
      wait_clks(6);
      v0 = n_valid;
      n_checks++;
      if (q.size() != 0) begin
         n_err++; $display("FAIL hold_high_drain: got %0d pending required 0", q.size());
      end
      wait_clks(-6 + 0);
      check_timeout_hold("hold_high", v0);
      pwm_in = 1'b0;
      wait_clks(40);
      n_checks++;
      if (timeout !== 1'b1) begin
         n_err++; $display("FAIL resume_pending: got timeout=%0b required 1", timeout);
      end
      drive_period(51, PER, 0, 1'b1, 1'b1);
   endtask

   task automatic test_hold_low();
      int v0;
      pwm_in = 1'b1;
      wait_clks(41 * TD);
      n_checks++;
      if (timeout !== 1'b0) begin
         n_err++; $display("FAIL timeout_clear: got timeout=%0b required 0", timeout);
      end
      n_checks++;
      if (q.size() != 0) begin
         n_err++; $display("FAIL hold_low_drain: got %0d pending required 0", q.size());
      end
      v0 = n_valid;
      pwm_in = 1'b0;
      check_timeout_hold("hold_low", v0);
      drive_period(61, PER, 0, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid();
      int v0;
      pwm_in = 1'b1;
      wait_clks(61 * TD);
      pwm_in = 1'b0;
      wait_clks(200 * TD);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({high_cnt, period_cnt, scancode, match, valid, timeout} !== '0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got h=%0d p=%0d sc=%02h m=%0b v=%0b to=%0b required all 0",
                  high_cnt, period_cnt, scancode, match, valid, timeout);
      end
      wait_clks(3);
      reset = 1'b0;
      wait_clks(7);
      v0 = n_valid;
      drive_period(81, PER, 0, 1'b1, 1'b1);
      n_checks++;
      if (n_valid !== v0) begin
         n_err++; $display("FAIL reset_first_rise: got %0d valids required %0d", n_valid, v0);
      end
      drive_period(43, PER, 0, 1'b1, 1'b1);
      pwm_in = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) wait_clks(1);
      n_checks++;
      if (q.size() != 0) begin
         n_err++; $display("FAIL drain_final: got %0d pending required 0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_codes();
      test_tolerance();
      test_tick_phase();
      test_hold_high();
      test_hold_low();
      test_reset_mid();
      wait_clks(4);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
